dis_wei: RTL

- Weight distributor between the global weight buffer (GBFWEI SRAM) and the weight-config controller (CTRLWEI).
- Reads fixed-size weight blocks from GBFWEI, packs each into one wide PEC weight word, holds it with rdy_wei.
- Two-entry prefetch buffer: a fetch pulse from CTRLWEI pops the current block and exposes the next on the following cycle, without SRAM read latency.

---
 rtl/dis_wei_pkg.sv | 24 ++
 rtl/wei_pack_fifo.sv | 68 ++++++
 rtl/dis_wei.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dis_wei_pkg.sv
// Shared definitions for the weight distributor: default widths, FSM
// encoding and small sizing helpers.
package dis_wei_pkg;

  localparam int DEF_GBF_DW = 96;
  localparam int DEF_GBF_AW = 10;
  localparam int DEF_WPB    = 3;
  localparam int DEF_BLK_W  = 8;
  localparam int NUMPEC     = 16;
  // Prefetch depth: one block on display, one block staged behind it.
  localparam int NUM_ENT    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } wei_state_e;

  // Width of a counter over 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wei_pack_fifo.sv
// Two-entry wide FIFO. The tail entry is built one GBF word at a time; the
// last word pushes it. Head entry drives the PEC weight word directly.
module wei_pack_fifo
  import dis_wei_pkg::*;
#(
  parameter int DW  = DEF_GBF_DW,
  parameter int WPB = DEF_WPB,
  parameter int IW  = idx_w(WPB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_wr_en,
  input  logic [IW-1:0]     i_wr_idx,
  input  logic              i_wr_last,
  input  logic [DW-1:0]     i_wr_data,
  input  logic              i_pop,
  output logic              o_vld,
  output logic [DW*WPB-1:0] o_data
);

  logic [1:0][WPB-1:0][DW-1:0] r_mem;
  logic [1:0]                  r_vld;
  logic                        r_wp;
  logic                        r_rp;
  logic                        w_push;
  logic                        w_pop;

  // A push into an occupied slot would overwrite a pending block; the
  // credit scheme upstream never allows it, the guard keeps order intact.
  assign w_push = i_wr_en & i_wr_last & ~r_vld[r_wp];
  assign w_pop  = i_pop & r_vld[r_rp];

  // Slice write into the tail entry as each word comes back from SRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else if (i_wr_en && !i_flush) begin
      r_mem[r_wp][i_wr_idx] <= i_wr_data;
    end
  end

  // Valid bits and pointers; push and pop touch different entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
    end else if (i_flush) begin
      r_vld <= '0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
    end else begin
      if (w_push) begin
        r_vld[r_wp] <= 1'b1;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_vld[r_rp] <= 1'b0;
        r_rp        <= ~r_rp;
      end
    end
  end

  assign o_vld  = r_vld[r_rp];
  assign o_data = r_mem[r_rp];

endmodule

// File: rtl/dis_wei.sv
// Weight distributor: streams fixed-size weight blocks out of GBFWEI in a
// loop, packs each into one wide word and keeps up to two blocks ready for
// CTRLWEI so a fetch never waits on SRAM latency.
module dis_wei
  import dis_wei_pkg::*;
#(
  parameter int GBF_DW = DEF_GBF_DW,
  parameter int GBF_AW = DEF_GBF_AW,
  parameter int WPB    = DEF_WPB,
  parameter int BLK_W  = DEF_BLK_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sta,
  input  logic                  stop,
  input  logic [GBF_AW-1:0]     cfg_base,
  input  logic [BLK_W-1:0]      cfg_nblk,
  output logic                  gbf_rd_en,
  output logic [GBF_AW-1:0]     gbf_rd_addr,
  input  logic [GBF_DW-1:0]     gbf_rd_data,
  input  logic                  plsfetch,
  output logic                  rdy_wei,
  output logic [GBF_DW*WPB-1:0] wei_data,
  output logic                  busy
);

  localparam int IW = idx_w(WPB);

  wei_state_e        r_state;
  wei_state_e        w_state_nxt;

  logic [GBF_AW-1:0] r_base;
  logic [BLK_W-1:0]  r_nblk;
  logic [BLK_W-1:0]  r_blk_idx;
  logic [GBF_AW-1:0] r_blk_addr;
  logic [IW-1:0]     r_widx;
  // Blocks owned by the buffer: valid entries plus the block being read.
  logic [1:0]        r_alloc;
  // Read return tracking: SRAM data is valid one cycle after the strobe.
  logic              r_rd_vld;
  logic [IW-1:0]     r_rd_widx;

  logic              w_rd_en;
  logic              w_first;
  logic              w_last;
  logic              w_pop;
  logic              w_head_vld;
  logic              w_wr_last;
  logic [1:0]        w_alloc_nxt;
  logic [IW-1:0]     w_widx_nxt;
  logic [BLK_W-1:0]  w_nblk_eff;

  assign w_rd_en    = (r_state == ST_FILL);
  assign w_first    = w_rd_en && (r_widx == '0);
  assign w_last     = w_rd_en && (r_widx == IW'(WPB - 1));
  // Fetches while nothing is on display are preload pulses; drop them.
  assign w_pop      = plsfetch & w_head_vld;
  assign w_alloc_nxt = r_alloc + 2'(w_first) - 2'(w_pop);
  assign w_widx_nxt = w_last ? '0 : (w_rd_en ? r_widx + 1'b1 : r_widx);
  assign w_nblk_eff = (cfg_nblk == '0) ? BLK_W'(1) : cfg_nblk;
  assign w_wr_last  = r_rd_vld && (r_rd_widx == IW'(WPB - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: stay in FILL while a block is mid-read or credit remains;
  // park in HOLD once two blocks are owned and no block is open.
  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = ST_IDLE;
    end else if (sta) begin
      w_state_nxt = ST_FILL;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_FILL, ST_HOLD: begin
          if ((w_alloc_nxt == 2'(NUM_ENT)) && (w_widx_nxt == '0))
            w_state_nxt = ST_HOLD;
          else
            w_state_nxt = ST_FILL;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Address walk, credit accounting and read-return tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_nblk     <= '0;
      r_blk_idx  <= '0;
      r_blk_addr <= '0;
      r_widx     <= '0;
      r_alloc    <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_widx  <= '0;
    end else if (stop) begin
      r_base     <= '0;
      r_nblk     <= '0;
      r_blk_idx  <= '0;
      r_blk_addr <= '0;
      r_widx     <= '0;
      r_alloc    <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_widx  <= '0;
    end else if (sta) begin
      // Restart drops any read still in flight by clearing its tag.
      r_base     <= cfg_base;
      r_nblk     <= w_nblk_eff;
      r_blk_idx  <= '0;
      r_blk_addr <= cfg_base;
      r_widx     <= '0;
      r_alloc    <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_widx  <= '0;
    end else begin
      r_alloc   <= w_alloc_nxt;
      r_widx    <= w_widx_nxt;
      r_rd_vld  <= w_rd_en;
      r_rd_widx <= r_widx;
      if (w_last) begin
        if (r_blk_idx == r_nblk - 1'b1) begin
          r_blk_idx  <= '0;
          r_blk_addr <= r_base;
        end else begin
          r_blk_idx  <= r_blk_idx + 1'b1;
          r_blk_addr <= r_blk_addr + GBF_AW'(WPB);
        end
      end
    end
  end

  wei_pack_fifo #(
    .DW  (GBF_DW),
    .WPB (WPB),
    .IW  (IW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (sta | stop),
    .i_wr_en   (r_rd_vld),
    .i_wr_idx  (r_rd_widx),
    .i_wr_last (w_wr_last),
    .i_wr_data (gbf_rd_data),
    .i_pop     (w_pop),
    .o_vld     (w_head_vld),
    .o_data    (wei_data)
  );

  assign gbf_rd_en   = w_rd_en;
  assign gbf_rd_addr = w_rd_en ? (r_blk_addr + GBF_AW'(r_widx)) : '0;
  assign rdy_wei     = w_head_vld;
  assign busy        = (r_state != ST_IDLE);

endmodule
